// File: rtl/status_input_conditioner_pkg.sv
// Status input conditioner: shared selection codes and types.
// Used by the conditioner front end and by select_mensage.
package status_input_conditioner_pkg;

    localparam logic [1:0] ST_NONE    = 2'b00;
    localparam logic [1:0] ST_ACEITO  = 2'b01;
    localparam logic [1:0] ST_COMPROM = 2'b10;
    localparam logic [1:0] ST_REJEIT  = 2'b11;

    typedef enum logic [1:0] {
        S_NONE    = ST_NONE,
        S_ACEITO  = ST_ACEITO,
        S_COMPROM = ST_COMPROM,
        S_REJEIT  = ST_REJEIT
    } sel_state_t;

    // Press vector is {rejeitado, comprometido, aceito}.
    // Highest button wins when several press in the same cycle.
    function automatic sel_state_t sel_encode(input logic [2:0] press);
        sel_state_t sel;
        sel = S_NONE;
        if (press[2])
            sel = S_REJEIT;
        else if (press[1])
            sel = S_COMPROM;
        else if (press[0])
            sel = S_ACEITO;
        return sel;
    endfunction

endpackage

// File: rtl/status_input_conditioner_if.sv
// Status input conditioner: button inputs and conditioned outputs.
// master drives the buttons, slave is the conditioner itself.
interface status_input_conditioner_if;

    logic       aceito;
    logic       comprometido;
    logic       rejeitado;
    logic [1:0] status;
    logic       restart;
    logic [2:0] btn_stable;
    logic       valid;

    modport master (
        output aceito,
        output comprometido,
        output rejeitado,
        input  status,
        input  restart,
        input  btn_stable,
        input  valid
    );

    modport slave (
        input  aceito,
        input  comprometido,
        input  rejeitado,
        output status,
        output restart,
        output btn_stable,
        output valid
    );

endinterface

// File: rtl/status_input_conditioner_debounce_cell.sv
// Status input conditioner: one button channel.
// Two-flop synchroniser followed by a hold-time debounce counter.
module status_input_conditioner_debounce_cell #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after it has held for the full window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (sync2 == stable) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            stable <= sync2;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/status_input_conditioner.sv
// Status input conditioner: debounced buttons to latched message code.
// Emits a one-cycle restart on every new press event.
module status_input_conditioner
    import status_input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input logic                          clk50Mhz,
    input logic                          rst,
    status_input_conditioner_if.slave    bus
);

    logic [2:0] raw;
    logic [2:0] stable;
    logic [2:0] stable_d;
    logic [2:0] press;
    sel_state_t sel;
    sel_state_t state;
    logic       restart_q;
    logic       valid_q;

    assign raw = {bus.rejeitado, bus.comprometido, bus.aceito};

    for (genvar i = 0; i < 3; i++) begin : g_cell
        status_input_conditioner_debounce_cell #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_cell (
            .clk    (clk50Mhz),
            .rst    (rst),
            .raw    (raw[i]),
            .stable (stable[i])
        );
    end

    assign press = stable & ~stable_d;
    assign sel   = sel_encode(press);

    // Selection FSM: any press event jumps to its state and pulses restart.
    always_ff @(posedge clk50Mhz or negedge rst) begin
        if (!rst) begin
            stable_d  <= 3'b000;
            state     <= S_NONE;
            restart_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            stable_d  <= stable;
            restart_q <= 1'b0;
            if (sel != S_NONE) begin
                state     <= sel;
                restart_q <= 1'b1;
                valid_q   <= 1'b1;
            end
        end
    end

    assign bus.status     = state;
    assign bus.restart    = restart_q;
    assign bus.btn_stable = stable;
    assign bus.valid      = valid_q;

endmodule

// File: tb/tb_status_input_conditioner.sv
// Directed bench for status_input_conditioner.
// Short debounce window so every scenario runs in a few hundred cycles.
module tb_status_input_conditioner;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   rcount;

    status_input_conditioner_if bus ();

    status_input_conditioner #(
        .DEBOUNCE_CYCLES (8),
        .CNT_W           (4)
    ) dut (
        .clk50Mhz (clk),
        .rst      (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Count cycles with restart high, sampled away from the active edge.
    always @(negedge clk) begin
        if (bus.restart === 1'b1)
            rcount <= rcount + 1;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(2);
        rst = 1'b1;
        rcount = 0;
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        rcount           = 0;
        rst              = 1'b0;
        bus.aceito       = 1'b1;
        bus.comprometido = 1'b0;
        bus.rejeitado    = 1'b0;

        // 1: reset holds everything low, then first press
        step(3);
        check("rst_status", 32'(bus.status), 32'd0);
        check("rst_restart", 32'(bus.restart), 32'd0);
        check("rst_stable", 32'(bus.btn_stable), 32'd0);
        check("rst_valid", 32'(bus.valid), 32'd0);
        rst = 1'b1;
        step(9);
        check("t1_stable_early", 32'(bus.btn_stable), 32'd0);
        step(1);
        check("t1_stable", 32'(bus.btn_stable), 32'b001);
        check("t1_status_early", 32'(bus.status), 32'd0);
        step(1);
        check("t1_status", 32'(bus.status), 32'b01);
        check("t1_restart", 32'(bus.restart), 32'd1);
        check("t1_valid", 32'(bus.valid), 32'd1);
        step(1);
        check("t1_restart_end", 32'(bus.restart), 32'd0);
        check("t1_status_hold", 32'(bus.status), 32'b01);

        // 2: bouncing input never accepted
        bus.aceito = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            bus.aceito = ~bus.aceito;
            step(3);
        end
        bus.aceito = 1'b0;
        step(20);
        check("t2_status", 32'(bus.status), 32'd0);
        check("t2_restarts", 32'(rcount), 32'd0);
        check("t2_stable", 32'(bus.btn_stable), 32'd0);
        check("t2_valid", 32'(bus.valid), 32'd0);

        // 3: simultaneous press, rejeitado wins, one pulse
        bus.aceito    = 1'b1;
        bus.rejeitado = 1'b1;
        step(20);
        check("t3_status", 32'(bus.status), 32'b11);
        check("t3_restarts", 32'(rcount), 32'd1);
        check("t3_stable", 32'(bus.btn_stable), 32'b101);
        bus.aceito    = 1'b0;
        bus.rejeitado = 1'b0;
        step(20);
        check("t3_release", 32'(bus.status), 32'b11);

        // 4: latch through release, re-press pulses again
        rcount = 0;
        bus.comprometido = 1'b1;
        step(20);
        check("t4_status", 32'(bus.status), 32'b10);
        check("t4_restarts", 32'(rcount), 32'd1);
        bus.comprometido = 1'b0;
        step(20);
        check("t4_latched", 32'(bus.status), 32'b10);
        check("t4_stable_rel", 32'(bus.btn_stable), 32'd0);
        bus.comprometido = 1'b1;
        step(20);
        check("t4_repress", 32'(bus.status), 32'b10);
        check("t4_restarts2", 32'(rcount), 32'd2);
        bus.comprometido = 1'b0;
        step(20);

        // 5: overlapping buttons
        rcount = 0;
        bus.aceito = 1'b1;
        step(20);
        check("t5_aceito", 32'(bus.status), 32'b01);
        bus.rejeitado = 1'b1;
        step(20);
        check("t5_rejeit", 32'(bus.status), 32'b11);
        check("t5_restarts", 32'(rcount), 32'd2);
        bus.rejeitado = 1'b0;
        step(20);
        check("t5_rel_status", 32'(bus.status), 32'b11);
        check("t5_rel_restarts", 32'(rcount), 32'd2);
        check("t5_stable", 32'(bus.btn_stable), 32'b001);
        bus.aceito = 1'b0;
        step(20);

        // 6: reset in the middle of a debounce count
        bus.rejeitado = 1'b1;
        step(5);
        rst = 1'b0;
        step(1);
        check("t6_rst_status", 32'(bus.status), 32'd0);
        check("t6_rst_valid", 32'(bus.valid), 32'd0);
        rst = 1'b1;
        rcount = 0;
        step(10);
        check("t6_stable", 32'(bus.btn_stable), 32'b100);
        check("t6_status_early", 32'(bus.status), 32'd0);
        step(1);
        check("t6_status", 32'(bus.status), 32'b11);
        check("t6_restart", 32'(bus.restart), 32'd1);
        step(1);
        check("t6_restarts", 32'(rcount), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
